// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// Holds the FSM state encoding, the op codes and the ALU control values.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABS_A  = 3'd1,
        S_ABS_B  = 3'd2,
        S_ITER   = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DEC_HI = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam int C_IDX = 1;

endpackage

// File: rtl/mul_seq.sv
// Multi-cycle MUL/UMULL/SMULL sequencer that runs a shift-add loop on the
// shared ALU adder. Signed products are formed from magnitudes and negated.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             n_flag,
    output logic             z_flag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output state_e           dbg_state
);

    // Handshake: start is sampled only in IDLE; busy is high from the cycle
    // after acceptance through the done cycle; done pulses once and results
    // stay valid until the next done. Starts while busy are dropped.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             lo_nz_q, lo_nz_d;
    logic             long_q, long_d;
    logic             smull_q, smull_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             n_q, n_d;
    logic             z_q, z_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            lo_nz_q  <= 1'b0;
            long_q   <= 1'b0;
            smull_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            lo_nz_q  <= lo_nz_d;
            long_q   <= long_d;
            smull_q  <= smull_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        lo_nz_d  = lo_nz_q;
        long_d   = long_q;
        smull_d  = smull_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = src_a;
                    mplr_d  = src_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    lo_nz_d = 1'b0;
                    smull_d = (op == OP_SMULL);
                    long_d  = (op == OP_UMULL) || (op == OP_SMULL);
                    sign_d  = (op == OP_SMULL) && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    state_d = (op == OP_SMULL) ? S_ABS_A : S_ITER;
                end
            end
            S_ABS_A: begin
                alu_b    = mcand_q;
                alu_ctrl = ALU_SUB;
                if (mcand_q[WIDTH-1]) mcand_d = alu_result;
                state_d  = S_ABS_B;
            end
            S_ABS_B: begin
                alu_b    = mplr_q;
                alu_ctrl = ALU_SUB;
                if (mplr_q[WIDTH-1]) mplr_d = alu_result;
                state_d  = S_ITER;
            end
            S_ITER: begin
                alu_a = hi_q;
                alu_b = mcand_q;
                // The low product word shifts in behind the consumed multiplier bits.
                if (mplr_q[0]) begin
                    {hi_d, mplr_d} = {alu_flags[C_IDX], alu_result, mplr_q[WIDTH-1:1]};
                end else begin
                    {hi_d, mplr_d} = {1'b0, hi_q, mplr_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) state_d = smull_q ? S_NEG_LO : S_DONE;
            end
            S_NEG_LO: begin
                alu_b    = mplr_q;
                alu_ctrl = ALU_SUB;
                lo_nz_d  = |mplr_q;
                if (sign_q) mplr_d = alu_result;
                state_d  = S_NEG_HI;
            end
            S_NEG_HI: begin
                alu_b    = hi_q;
                alu_ctrl = ALU_SUB;
                if (sign_q) hi_d = alu_result;
                state_d  = S_DEC_HI;
            end
            S_DEC_HI: begin
                // -{hi,lo} = {~hi + (lo == 0), -lo}: undo the +1 when lo was non-zero.
                alu_a   = hi_q;
                alu_b   = '1;
                if (sign_q && lo_nz_q) hi_d = alu_result;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        if (state_d == S_DONE) begin
            done_d   = 1'b1;
            res_lo_d = mplr_d;
            res_hi_d = long_q ? hi_d : '0;
            n_d      = long_q ? hi_d[WIDTH-1] : mplr_d[WIDTH-1];
            z_d      = long_q ? ((hi_d == '0) && (mplr_d == '0)) : (mplr_d == '0);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign n_flag    = n_q;
    assign z_flag    = z_q;
    assign dbg_state = state_q;

endmodule
